neuron_frame_loader: RTL

- Upstream feeder for a single fully-parallel 49-input floating-point neuron.
- Accepts a serial stream of unsigned integer pixels over a valid/ready handshake and converts each pixel to IEEE-754 single precision.
- Packs N_INPUTS pixels into a stable parallel vector, strobes it into the neuron, then waits out the neuron's fixed pipeline latency.
- Captures the neuron's activated output and presents it as a qualified result.

---
 rtl/neuron_frame_loader.sv | 116 +++++++++++
 1 files changed

// File: rtl/neuron_frame_loader.sv
// Serial pixel loader for a 49-input floating-point neuron.
// Accepts unsigned pixels over valid/ready and converts each one to IEEE-754
// single precision. A full frame is held as a stable parallel vector and
// strobed into the neuron. The loader then waits out the neuron's fixed
// pipeline latency and captures its output as a qualified result.
module neuron_frame_loader #(
    parameter int N_INPUTS       = 49,
    parameter int PIX_W          = 8,
    parameter int NEURON_LATENCY = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pix_valid,
    output logic                     pix_ready,
    input  logic [PIX_W-1:0]         pix_data,
    input  logic                     pix_last,
    output logic [N_INPUTS-1:0][31:0] vec_out,
    output logic                     vec_valid,
    input  logic [31:0]              neuron_out,
    output logic [31:0]              result,
    output logic                     result_valid,
    output logic                     frame_err
);

    localparam int                CNT_W    = $clog2(N_INPUTS);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(N_INPUTS - 1);
    localparam logic [5:0]        LAT_INIT = 6'(NEURON_LATENCY - 1);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [5:0]       lat;
    logic             accept;

    // Exact unsigned-to-float conversion. Any pixel of 24 bits or fewer fits
    // the 24-bit significand, so no rounding is ever needed.
    function automatic logic [31:0] to_float(input logic [PIX_W-1:0] v);
        logic [4:0]  p;
        logic [23:0] sig;
        // NOTE: every local gets a value before any conditional use, so no
        // storage is implied when this is evaluated combinationally.
        p = 5'd0;
        for (int i = 0; i < PIX_W; i++) begin
            if (v[i]) p = 5'(i);
        end
        sig = 24'(v) << (5'd23 - p);
        if (v == '0) return 32'h0000_0000;
        return {1'b0, 8'd127 + {3'b000, p}, sig[22:0]};
    endfunction

    // Pixels are only taken in LOAD, and never while reset is held.
    assign pix_ready = (state == S_LOAD) && !rst;
    assign accept    = pix_valid && pix_ready;

    // Frame FSM: load pixels, issue the vector, wait out the neuron latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: vec_out is a register bank driven straight into the
            // neuron, so it is cleared on reset rather than left undefined.
            state        <= S_LOAD;
            cnt          <= '0;
            lat          <= '0;
            vec_out      <= '0;
            vec_valid    <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch
            // below sees the values from before this clock edge.
            vec_valid    <= 1'b0;
            result_valid <= 1'b0;
            frame_err    <= 1'b0;
            case (state)
                S_LOAD: begin
                    if (accept) begin
                        vec_out[cnt] <= to_float(pix_data);
                        if (cnt == LAST_IDX) begin
                            // Full frame: issue it even if pix_last was missing.
                            cnt       <= '0;
                            state     <= S_ISSUE;
                            vec_valid <= 1'b1;
                            frame_err <= !pix_last;
                        end else if (pix_last) begin
                            // Early last: drop the partial frame and restart.
                            cnt       <= '0;
                            frame_err <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    lat   <= LAT_INIT;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (lat == 6'd0) begin
                        result       <= neuron_out;
                        result_valid <= 1'b1;
                        state        <= S_LOAD;
                    end else begin
                        lat <= lat - 1'b1;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule
